// File: rtl/pong_round_if.sv
// ============================================================================
// Module : pong_round_if
// Brief  : Frame/point/button inputs and score/overlay outputs of the Pong
//          round controller, grouped with source-side and controller modports.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pong_round_if;
    logic       fsync;
    logic       point_p1;
    logic       point_p2;
    logic       start;
    logic       obj_rst;
    logic       game_over;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [1:0] winner;
    logic       serve_dir;
    logic [1:0] state;

    modport master (
        output fsync, point_p1, point_p2, start,
        input  obj_rst, game_over, p1_score, p2_score, winner, serve_dir, state
    );

    modport slave (
        input  fsync, point_p1, point_p2, start,
        output obj_rst, game_over, p1_score, p2_score, winner, serve_dir, state
    );
endinterface

`default_nettype wire

// File: rtl/pong_round_ctrl.sv
// ============================================================================
// Module : pong_round_ctrl
// Brief  : Pong match sequencer (serve hold, play, point pause, match over),
//          frame-counted timing, score registers and overlay/reset control.
//          Optional macro SERVE_ALTERNATE_EN: alternate serve direction each point.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pong_round_ctrl #(
    parameter int SERVE_FRAMES = 32,
    parameter int PAUSE_FRAMES = 128,
    parameter int WIN_SCORE    = 9,
    parameter int CW           = 8
) (
    input  wire logic   pixel_clk,
    input  wire logic   rst,
    pong_round_if.slave bus
);

    typedef enum logic [1:0] {
        S_SERVE      = 2'd0,
        S_PLAY       = 2'd1,
        S_POINT      = 2'd2,
        S_MATCH_OVER = 2'd3
    } state_t;

    localparam logic [CW-1:0] c_SERVE_LAST = CW'(SERVE_FRAMES - 1);
    localparam logic [CW-1:0] c_PAUSE_LAST = CW'(PAUSE_FRAMES - 1);
    localparam logic [CW-1:0] c_CNT_MAX    = {CW{1'b1}};
    localparam logic [3:0]    c_WIN        = 4'(WIN_SCORE);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_start_q;
    logic          r_obj_rst;
    logic          r_game_over;
    logic [3:0]    r_p1;
    logic [3:0]    r_p2;
    logic [1:0]    r_winner;
    logic          r_serve_dir;

    logic [CW-1:0] w_cnt_inc;
    logic          w_start_rise;
    logic          w_dir_p1;
    logic          w_dir_p2;

    assign w_cnt_inc    = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + CW'(1);
    assign w_start_rise = bus.start & ~r_start_q;

`ifdef SERVE_ALTERNATE_EN
    assign w_dir_p1 = ~r_serve_dir;
    assign w_dir_p2 = ~r_serve_dir;
`else
    // Serve toward whoever just lost the point.
    assign w_dir_p1 = 1'b0;
    assign w_dir_p2 = 1'b1;
`endif

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_state     <= S_SERVE;
            r_cnt       <= '0;
            r_start_q   <= 1'b0;
            r_obj_rst   <= 1'b1;
            r_game_over <= 1'b0;
            r_p1        <= 4'd0;
            r_p2        <= 4'd0;
            r_winner    <= 2'd0;
            r_serve_dir <= 1'b0;
        end else begin
            r_start_q <= bus.start;
            case (r_state)
                S_SERVE: begin
                    if (bus.fsync) begin
                        if (r_cnt == c_SERVE_LAST) begin
                            r_state     <= S_PLAY;
                            r_cnt       <= '0;
                            r_obj_rst   <= 1'b0;
                            r_game_over <= 1'b0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                S_PLAY: begin
                    // Simultaneous misses are a dead ball: re-serve, nobody scores.
                    if (bus.point_p1 && bus.point_p2) begin
                        r_state   <= S_SERVE;
                        r_cnt     <= '0;
                        r_obj_rst <= 1'b1;
                    end else if (bus.point_p1) begin
                        if (r_p1 != c_WIN) r_p1 <= r_p1 + 4'd1;
                        r_serve_dir <= w_dir_p1;
                        r_state     <= S_POINT;
                        r_cnt       <= '0;
                        r_obj_rst   <= 1'b1;
                        r_game_over <= 1'b1;
                    end else if (bus.point_p2) begin
                        if (r_p2 != c_WIN) r_p2 <= r_p2 + 4'd1;
                        r_serve_dir <= w_dir_p2;
                        r_state     <= S_POINT;
                        r_cnt       <= '0;
                        r_obj_rst   <= 1'b1;
                        r_game_over <= 1'b1;
                    end
                end
                S_POINT: begin
                    if (bus.fsync) begin
                        if (r_cnt == c_PAUSE_LAST) begin
                            r_cnt <= '0;
                            if (r_p1 == c_WIN) begin
                                r_winner <= 2'd1;
                                r_state  <= S_MATCH_OVER;
                            end else if (r_p2 == c_WIN) begin
                                r_winner <= 2'd2;
                                r_state  <= S_MATCH_OVER;
                            end else begin
                                r_state     <= S_SERVE;
                                r_game_over <= 1'b0;
                            end
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                S_MATCH_OVER: begin
                    if (w_start_rise) begin
                        r_p1        <= 4'd0;
                        r_p2        <= 4'd0;
                        r_winner    <= 2'd0;
                        r_state     <= S_SERVE;
                        r_cnt       <= '0;
                        r_game_over <= 1'b0;
                        r_obj_rst   <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_SERVE;
                    r_cnt       <= '0;
                    r_obj_rst   <= 1'b1;
                    r_game_over <= 1'b0;
                end
            endcase
        end
    end

    assign bus.obj_rst   = r_obj_rst;
    assign bus.game_over = r_game_over;
    assign bus.p1_score  = r_p1;
    assign bus.p2_score  = r_p2;
    assign bus.winner    = r_winner;
    assign bus.serve_dir = r_serve_dir;
    assign bus.state     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pong_round_ctrl.sv
// ============================================================================
// Module : tb_pong_round_ctrl
// Brief  : Self-checking bench for pong_round_ctrl: directed match scenarios
//          followed by randomized play, checked every cycle against a model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pong_round_ctrl;

    localparam int SERVE_FRAMES = 32;
    localparam int PAUSE_FRAMES = 128;
    localparam int WIN_SCORE    = 9;
    localparam int CW           = 8;
    localparam int MAX_BAD      = 50;

`ifdef SERVE_ALTERNATE_EN
    localparam bit ALT = 1'b1;
`else
    localparam bit ALT = 1'b0;
`endif

    logic pixel_clk = 1'b0;
    logic rst       = 1'b1;
    int   n_cmp     = 0;
    int   n_bad     = 0;

    pong_round_if intf ();

    pong_round_ctrl #(
        .SERVE_FRAMES (SERVE_FRAMES),
        .PAUSE_FRAMES (PAUSE_FRAMES),
        .WIN_SCORE    (WIN_SCORE),
        .CW           (CW)
    ) dut (
        .pixel_clk (pixel_clk),
        .rst       (rst),
        .bus       (intf.slave)
    );

    always #5 pixel_clk = ~pixel_clk;

    // Reference: match phase plus frames remaining in the current hold.
    int m_mode    = 0;
    int m_left    = SERVE_FRAMES;
    int m_p1      = 0;
    int m_p2      = 0;
    int m_win     = 0;
    int m_dir     = 0;
    int m_start_q = 0;

    always @(posedge pixel_clk) begin
        int sp;
        if (rst) begin
            m_mode = 0; m_left = SERVE_FRAMES; m_p1 = 0; m_p2 = 0;
            m_win = 0; m_dir = 0; m_start_q = 0;
        end else begin
            sp = m_start_q;
            m_start_q = intf.start;
            if (m_mode == 0) begin
                if (intf.fsync) begin
                    m_left--;
                    if (m_left == 0) m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (intf.point_p1 && intf.point_p2) begin
                    m_mode = 0; m_left = SERVE_FRAMES;
                end else if (intf.point_p1 || intf.point_p2) begin
                    if (intf.point_p1) m_p1 = (m_p1 < WIN_SCORE) ? m_p1 + 1 : m_p1;
                    else               m_p2 = (m_p2 < WIN_SCORE) ? m_p2 + 1 : m_p2;
                    m_dir  = ALT ? 1 - m_dir : (intf.point_p1 ? 0 : 1);
                    m_mode = 2; m_left = PAUSE_FRAMES;
                end
            end else if (m_mode == 2) begin
                if (intf.fsync) begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_p1 == WIN_SCORE)      begin m_win = 1; m_mode = 3; end
                        else if (m_p2 == WIN_SCORE) begin m_win = 2; m_mode = 3; end
                        else begin m_mode = 0; m_left = SERVE_FRAMES; end
                    end
                end
            end else begin
                if (intf.start && !sp) begin
                    m_p1 = 0; m_p2 = 0; m_win = 0; m_mode = 0; m_left = SERVE_FRAMES;
                end
            end
        end
        #1;
        n_cmp++;
        if (intf.state !== 2'(m_mode) || intf.obj_rst !== (m_mode != 1) ||
            intf.game_over !== (m_mode >= 2) || intf.p1_score !== 4'(m_p1) ||
            intf.p2_score !== 4'(m_p2) || intf.winner !== 2'(m_win) ||
            intf.serve_dir !== 1'(m_dir)) begin
            n_bad++;
            $display("FAIL cycle t=%0t: got st=%0d obj_rst=%0b go=%0b p1=%0d p2=%0d win=%0d dir=%0b, expected st=%0d obj_rst=%0b go=%0b p1=%0d p2=%0d win=%0d dir=%0d",
                     $time, intf.state, intf.obj_rst, intf.game_over, intf.p1_score,
                     intf.p2_score, intf.winner, intf.serve_dir, m_mode, (m_mode != 1),
                     (m_mode >= 2), m_p1, m_p2, m_win, m_dir);
            if (n_bad >= MAX_BAD) begin
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge pixel_clk);
    endtask

    task automatic frames(input int n, input int period);
        for (int i = 0; i < n; i++) begin
            intf.fsync = 1'b1;
            @(negedge pixel_clk);
            intf.fsync = 1'b0;
            cyc(period - 1);
        end
    endtask

    task automatic pulse(input bit a, input bit b);
        intf.point_p1 = a;
        intf.point_p2 = b;
        @(negedge pixel_clk);
        intf.point_p1 = 1'b0;
        intf.point_p2 = 1'b0;
    endtask

    initial begin
        bit fs_q, a_q, b_q;
        intf.fsync = 1'b0; intf.point_p1 = 1'b0; intf.point_p2 = 1'b0; intf.start = 1'b0;
        rst = 1'b1;
        cyc(3);
        check("reset state", intf.state, 0);
        check("reset obj_rst", intf.obj_rst, 1);
        check("reset game_over", intf.game_over, 0);
        check("reset scores", {intf.p1_score, intf.p2_score}, 0);
        check("reset winner/dir", {intf.winner, intf.serve_dir}, 0);
        rst = 1'b0;

        frames(SERVE_FRAMES - 1, 100);
        check("serve hold 31 frames", {intf.state, intf.obj_rst}, 3'b001);
        frames(1, 100);
        check("play after 32 frames", {intf.state, intf.obj_rst}, 3'b010);

        pulse(1, 0);
        check("p1 point score", intf.p1_score, 1);
        check("p1 point overlay/state", {intf.game_over, intf.state}, 3'b110);
        check("serve_dir after 1st p1", intf.serve_dir, ALT ? 1 : 0);
        pulse(1, 0);
        check("p1 ignored in POINT", intf.p1_score, 1);
        frames(PAUSE_FRAMES - 1, 4);
        check("pause not yet over", intf.state, 2);
        frames(1, 4);
        check("pause over state/go", {intf.state, intf.game_over}, 3'b000);
        pulse(1, 0);
        check("p1 ignored in SERVE", {intf.p1_score, intf.state}, {4'd1, 2'd0});

        frames(SERVE_FRAMES, 2);
        pulse(1, 0);
        check("serve_dir after 2nd p1", {intf.serve_dir, intf.p1_score}, {1'b0, 4'd2});
        frames(PAUSE_FRAMES, 2);
        frames(SERVE_FRAMES, 2);
        pulse(0, 1);
        check("serve_dir after p2", {intf.serve_dir, intf.p2_score}, {1'b1, 4'd1});
        frames(PAUSE_FRAMES, 2);
        frames(SERVE_FRAMES, 2);
        pulse(1, 1);
        check("double point", {intf.p1_score, intf.p2_score, intf.state, intf.serve_dir},
              {4'd2, 4'd1, 2'd0, 1'b1});

        frames(SERVE_FRAMES, 2);
        for (int k = 0; k < 3; k++) begin
            pulse(1, 0);
            if (k < 2) begin
                frames(PAUSE_FRAMES, 2);
                frames(SERVE_FRAMES, 2);
            end
        end
        check("p1 at 5 in POINT", {intf.p1_score, intf.state}, {4'd5, 2'd2});
        frames(10, 2);
        rst = 1'b1;
        @(negedge pixel_clk);
        check("rst mid-POINT", {intf.p1_score, intf.state, intf.game_over, intf.obj_rst},
              {4'd0, 2'd0, 1'b0, 1'b1});
        rst = 1'b0;

        frames(SERVE_FRAMES, 2);
        for (int k = 0; k < WIN_SCORE; k++) begin
            if (k == WIN_SCORE - 1) intf.start = 1'b1;
            pulse(0, 1);
            frames(PAUSE_FRAMES, 2);
            if (k < WIN_SCORE - 1) frames(SERVE_FRAMES, 2);
        end
        check("p2 wins", {intf.winner, intf.state, intf.p2_score, intf.game_over},
              {2'd2, 2'd3, 4'd9, 1'b1});
        cyc(5);
        check("held start ignored", {intf.state, intf.p2_score}, {2'd3, 4'd9});
        intf.start = 1'b0;
        cyc(2);
        intf.start = 1'b1;
        @(negedge pixel_clk);
        check("start edge restart", {intf.state, intf.p2_score, intf.winner}, {2'd0, 4'd0, 2'd0});
        intf.start = 1'b0;

        fs_q = 0; a_q = 0; b_q = 0;
        for (int c = 0; c < 20000; c++) begin
            intf.fsync    = !fs_q && ($urandom_range(2) == 0);
            intf.point_p1 = !a_q && ($urandom_range(15) == 0);
            intf.point_p2 = !b_q && ($urandom_range(15) == 0);
            if ($urandom_range(39) == 0) intf.start = ~intf.start;
            rst = ($urandom_range(4999) == 0);
            fs_q = intf.fsync; a_q = intf.point_p1; b_q = intf.point_p2;
            @(negedge pixel_clk);
        end
        rst = 1'b0;
        intf.fsync = 1'b0; intf.point_p1 = 1'b0; intf.point_p2 = 1'b0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
